// File: rtl/nmos_inv_if.sv
// Signal bundle for one nmos_inv instance: inverter pins plus transition counter.
// The master side drives the input level; the slave side (the inverter) drives out and the count.
interface nmos_inv_if;
    logic        in;
    logic        out;
    logic [15:0] toggle_cnt;

    modport master (output in, input out, input toggle_cnt);
    modport slave  (input in, output out, output toggle_cnt);
endinterface

// File: rtl/nmos_inv.sv
// Filtered, pipelined inverter with a saturating output-transition counter.
// Optional macro NMOS_INV_XPROP_EN: X/Z samples force the accepted level to X instead of being ignored.
module nmos_inv #(
    parameter int FILTER = 1,
    parameter int DELAY  = 1
) (
    output logic        out,
    input  logic        in,
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] toggle_cnt
);
    localparam logic [3:0] FILTER_W = 4'(FILTER);

    logic [3:0]       r_stab_cnt;
    logic             r_prev;
    logic             r_level;
    logic [DELAY-1:0] r_pipe;
    logic [15:0]      r_toggle_cnt;

    logic             w_in_valid;
    logic [3:0]       w_cnt_next;
    logic             w_level_next;
    logic [DELAY-1:0] w_pipe_next;
    logic             w_out_old;
    logic             w_out_new;
    logic             w_out_toggles;

    // Compares against constants only, so synthesis folds this to 1.
    assign w_in_valid = (in === 1'b0) || (in === 1'b1);

    // A count of 0 means no valid history, so the next valid sample always starts at 1.
    always_comb begin
        w_cnt_next   = r_stab_cnt;
        w_level_next = r_level;
        if (w_in_valid) begin
            if ((r_stab_cnt != 4'd0) && (in == r_prev)) begin
                w_cnt_next = (r_stab_cnt >= FILTER_W) ? FILTER_W : r_stab_cnt + 4'd1;
            end else begin
                w_cnt_next = 4'd1;
            end
            if (w_cnt_next >= FILTER_W) begin
                w_level_next = in;
            end
        end else begin
            w_cnt_next = 4'd0;
`ifdef NMOS_INV_XPROP_EN
            w_level_next = 1'bx;
`endif
        end
    end

    // Stage 0 sees the new accepted level on the same edge, giving one-cycle latency at DELAY=1.
    always_comb begin
        w_pipe_next    = r_pipe;
        w_pipe_next[0] = ~w_level_next;
        for (int i = 1; i < DELAY; i++) begin
            w_pipe_next[i] = r_pipe[i-1];
        end
    end

    assign w_out_old = r_pipe[DELAY-1];
    assign w_out_new = w_pipe_next[DELAY-1];

`ifdef NMOS_INV_XPROP_EN
    assign w_out_toggles = ((w_out_old === 1'b0) && (w_out_new === 1'b1)) ||
                           ((w_out_old === 1'b1) && (w_out_new === 1'b0));
`else
    assign w_out_toggles = (w_out_old != w_out_new);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stab_cnt   <= 4'd0;
            r_prev       <= 1'b0;
            r_level      <= 1'b0;
            r_pipe       <= '1;
            r_toggle_cnt <= 16'd0;
        end else begin
            r_stab_cnt <= w_cnt_next;
            r_level    <= w_level_next;
            r_pipe     <= w_pipe_next;
            if (w_in_valid) begin
                r_prev <= in;
            end
            if (w_out_toggles && (r_toggle_cnt != 16'hFFFF)) begin
                r_toggle_cnt <= r_toggle_cnt + 16'd1;
            end
        end
    end

    assign out        = r_pipe[DELAY-1];
    assign toggle_cnt = r_toggle_cnt;
endmodule

// File: tb/tb_nmos_inv.sv
// Bench for nmos_inv: default, FILTER=3 and DELAY=4 instances on one clock.
// Vector table with an expected-value queue, then hand sequences for filter, pipeline, X and saturation.
module tb_nmos_inv;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nmos_inv_if if_def ();
    nmos_inv_if if_f3 ();
    nmos_inv_if if_d4 ();

    nmos_inv #(.FILTER(1), .DELAY(1)) u_def (
        .out(if_def.out), .in(if_def.in), .clk(clk), .rst(rst), .toggle_cnt(if_def.toggle_cnt)
    );
    nmos_inv #(.FILTER(3), .DELAY(1)) u_f3 (
        .out(if_f3.out), .in(if_f3.in), .clk(clk), .rst(rst), .toggle_cnt(if_f3.toggle_cnt)
    );
    nmos_inv #(.FILTER(1), .DELAY(4)) u_d4 (
        .out(if_d4.out), .in(if_d4.in), .clk(clk), .rst(rst), .toggle_cnt(if_d4.toggle_cnt)
    );

    typedef struct {
        logic        rst;
        logic        in;
        logic        exp_out;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        vecs[11];
    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [16:0] got;
    logic        f3_in [10];
    logic        f3_out[10];
    logic        exp_x_out;
    logic [15:0] exp_x_cnt;

    initial begin
        rst       = 1'b1;
        if_def.in = 1'b0;
        if_f3.in  = 1'b0;
        if_d4.in  = 1'b0;

        // rst, in, out after edge, toggle_cnt after edge (default instance)
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'd2};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'd4};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'd4};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'd1};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst       = vecs[i].rst;
            if_def.in = vecs[i].in;
            exp_q.push_back({vecs[i].exp_out, vecs[i].exp_cnt});
            tick();
            got = exp_q.pop_front();
            check($sformatf("tbl%0d_out", i), {15'd0, if_def.out}, {15'd0, got[16]});
            check($sformatf("tbl%0d_cnt", i), if_def.toggle_cnt, got[15:0]);
        end
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        // X sample on the default instance (out=0, cnt=1 beforehand)
        if_def.in = 1'bx;
        if ((if_def.in === 1'b0) || (if_def.in === 1'b1)) begin
            exp_x_out = ~if_def.in;
            exp_x_cnt = (if_def.in === 1'b0) ? 16'd2 : 16'd1;
        end else begin
`ifdef NMOS_INV_XPROP_EN
            exp_x_out = 1'bx;
`else
            exp_x_out = 1'b0;
`endif
            exp_x_cnt = 16'd1;
        end
        tick();
        check("x_out", {15'd0, if_def.out}, {15'd0, exp_x_out});
        check("x_cnt", if_def.toggle_cnt, exp_x_cnt);
        if_def.in = 1'b0;

        // FILTER=3: short pulses rejected, three stable samples accepted
        reset_all();
        check("f3_rst_out", {15'd0, if_f3.out}, 16'd1);
        f3_in  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        f3_out = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if_f3.in = f3_in[i];
            tick();
            check($sformatf("f3_%0d_out", i), {15'd0, if_f3.out}, {15'd0, f3_out[i]});
            check($sformatf("f3_%0d_cnt", i), if_f3.toggle_cnt, (i >= 6) ? 16'd1 : 16'd0);
        end

        // DELAY=4: rising input reaches out after the fourth edge; reset mid-pipeline
        reset_all();
        if_d4.in = 1'b0;
        tick();
        check("d4_idle_out", {15'd0, if_d4.out}, 16'd1);
        if_d4.in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("d4_lat%0d_out", i), {15'd0, if_d4.out}, (i == 3) ? 16'd0 : 16'd1);
            check($sformatf("d4_lat%0d_cnt", i), if_d4.toggle_cnt, (i == 3) ? 16'd1 : 16'd0);
        end
        if_d4.in = 1'b0;
        tick();
        check("d4_hold_out", {15'd0, if_d4.out}, 16'd0);
        rst = 1'b1;
        tick();
        check("d4_midrst_out", {15'd0, if_d4.out}, 16'd1);
        check("d4_midrst_cnt", if_d4.toggle_cnt, 16'd0);
        rst = 1'b0;

        // Saturation of toggle_cnt, then reset mid-run
        if_def.in = 1'b0;
        tick();
        check("sat_pre_out", {15'd0, if_def.out}, 16'd1);
        force u_def.r_toggle_cnt = 16'hFFFE;
        #1;
        release u_def.r_toggle_cnt;
        for (int i = 0; i < 3; i++) begin
            if_def.in = ~if_def.in;
            tick();
            check($sformatf("sat%0d_out", i), {15'd0, if_def.out}, {15'd0, ~if_def.in});
            check($sformatf("sat%0d_cnt", i), if_def.toggle_cnt, 16'hFFFF);
        end
        rst = 1'b1;
        tick();
        check("sat_rst_out", {15'd0, if_def.out}, 16'd1);
        check("sat_rst_cnt", if_def.toggle_cnt, 16'd0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nmos_inv.md
NMOS_INV -- requirements
Module: nmos_inv

Interface
REQ-001 Parameter FILTER, default 1, number of consecutive identical input samples required before a new input level is accepted; legal range 1..15.
REQ-002 Parameter DELAY, default 1, output register pipeline depth in clk cycles; legal range 1..8.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port out  output  1  registered inverted value of the accepted input level.
REQ-006 Port in  input  1  logic input to be inverted; 4-state, asynchronous to nothing, sampled on clk.
REQ-007 Port toggle_cnt  output  16  count of out level transitions since reset.
REQ-008 Port order SHALL be out, in, then clk, rst, toggle_cnt, so positional instantiation nmos_inv(out, in, ...) connects the inverter pins first.

Function
REQ-009 in SHALL be sampled on every rising clk edge where rst is low.
REQ-010 The accepted level SHALL update to the sampled value on the edge where that value has been sampled on FILTER consecutive edges, including the current edge.
REQ-011 With FILTER=1, every valid 0/1 sample SHALL be accepted on its own edge.
REQ-012 A sample differing from the previous sample SHALL restart the stability count at 1.
REQ-013 out SHALL equal the inverse of the accepted level, delayed DELAY-1 further edges through the pipeline.
REQ-014 With defaults, out after edge k SHALL equal ~in as sampled at edge k: one-cycle latency.
REQ-015 General latency: out changes DELAY+FILTER-1 edges after the first edge that samples the new stable level.
REQ-016 toggle_cnt SHALL increment by 1 on each edge where the out register changes between 0 and 1.
REQ-017 toggle_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-018 Transitions into or out of X SHALL NOT be counted.
REQ-019 An input pulse shorter than FILTER samples SHALL produce no change on out and no toggle_cnt increment.

Reset
REQ-020 When rst is high at a rising edge, that edge SHALL apply reset, overriding all other behaviour, including mid-filter or mid-pipeline.
REQ-021 Reset values SHALL be:
- accepted level 0
- stability count 0
- all pipeline stages and out 1
- toggle_cnt 0
REQ-022 The first post-reset sample SHALL begin a fresh stability count; no pre-reset history is retained.

Configuration
REQ-023 Macro NMOS_INV_XPROP_EN selects X/Z handling on in.
REQ-024 With NMOS_INV_XPROP_EN defined:
- an X or Z sample SHALL set the accepted level to X immediately, bypassing FILTER;
- it SHALL reset the stability count;
- out SHALL become X after DELAY-1 further edges.
REQ-025 With NMOS_INV_XPROP_EN defined, recovery from X SHALL follow the normal FILTER rule.
REQ-026 Without NMOS_INV_XPROP_EN:
- X and Z samples SHALL be ignored;
- the stability count resets;
- the accepted level and out hold their values;
- synthesis SHALL produce no X-detection logic.

Verification
REQ-027 Defaults; rst=1 for 2 edges, then in=1 -> out=1 during reset, out=0 after first edge sampling in=1, toggle_cnt=1.
REQ-028 Defaults; toggle in 1,0,1,0 on successive edges -> out 0,1,0,1 one edge later each, toggle_cnt=4.
REQ-029 FILTER=3; in=1 for 2 edges then 0 -> out stays 1 and toggle_cnt stays 0; in=1 for 3 edges -> out=0 on third edge.
REQ-030 DELAY=4, FILTER=1; in 0->1 at edge k -> out falls after edge k+3.
REQ-031 NMOS_INV_XPROP_EN, defaults; in=x -> out=x next edge, toggle_cnt unchanged; without macro, in=x -> out holds.
REQ-032 Force toggle_cnt near 16'hFFFE and toggle 3 times -> saturates at 16'hFFFF; assert rst mid-run -> all reset values on that edge.
